// File: rtl/mul_div_controller_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Provides the operand width, the FUNCT3 M-op encodings, the 2-bit FSM
// state encoding, and small helpers for operand sign handling.
package mul_div_controller_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic op_signed1(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic op_signed2(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  // Two's complement negation of one word
  function automatic logic [MD_XLEN-1:0] neg_word(input logic [MD_XLEN-1:0] v);
    return -v;
  endfunction

endpackage

// File: rtl/mul_div_datapath.sv
// Datapath of the multiply/divide sequencer.
// Holds the operand magnitudes, the shared accumulator (product high/low
// or partial remainder/quotient), the sign flags and the RESULT register.
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   load          capture FUNCT3, operand magnitudes and sign flags
//   step          perform one shift-add or restoring-divide iteration
//   fix           apply sign correction and write the selected word to result
//   fast          write fast_result straight to result
//   funct3        M-op encoding (sampled on load)
//   data1, data2  rs1 / rs2 operands (sampled on load)
//   fast_result   precomputed divide-by-zero / overflow answer
//   result        registered operation result
module mul_div_datapath
  import mul_div_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               fast,
  input  logic [2:0]         funct3,
  input  logic [MD_XLEN-1:0] data1,
  input  logic [MD_XLEN-1:0] data2,
  input  logic [MD_XLEN-1:0] fast_result,
  output logic [MD_XLEN-1:0] result
);

  logic [2:0]           op_q, op_d;
  logic [MD_XLEN-1:0]   b_q, b_d;        // multiplicand or divisor magnitude
  logic [MD_XLEN-1:0]   hi_q, hi_d;      // product high word / remainder
  logic [MD_XLEN-1:0]   lo_q, lo_d;      // product low word / quotient
  logic                 neg_q, neg_d;    // product or quotient must be negated
  logic                 dvd_neg_q, dvd_neg_d;
  logic [MD_XLEN-1:0]   result_q, result_d;

  logic                 sgn1_s, sgn2_s;
  logic [MD_XLEN-1:0]   mag1_s, mag2_s;
  logic [MD_XLEN:0]     mul_sum_s;
  logic [MD_XLEN:0]     div_shift_s, div_diff_s;
  logic [2*MD_XLEN-1:0] prod_s, prod_fix_s;
  logic [MD_XLEN-1:0]   quo_fix_s, rem_fix_s, sel_s;

  assign sgn1_s = op_signed1(funct3) & data1[MD_XLEN-1];
  assign sgn2_s = op_signed2(funct3) & data2[MD_XLEN-1];
  assign mag1_s = sgn1_s ? neg_word(data1) : data1;
  assign mag2_s = sgn2_s ? neg_word(data2) : data2;

  // Shift-add: add the multiplicand when the multiplier LSB is set; the
  // carry out becomes the new MSB after the right shift.
  assign mul_sum_s = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};

  // Restoring divide: the 33-bit partial remainder is the old remainder
  // shifted left with the next dividend bit; a clear borrow keeps the
  // difference and sets the quotient bit.
  assign div_shift_s = {hi_q, lo_q[MD_XLEN-1]};
  assign div_diff_s  = div_shift_s - {1'b0, b_q};

  assign prod_s     = {hi_q, lo_q};
  assign prod_fix_s = neg_q ? -prod_s : prod_s;
  assign quo_fix_s  = neg_q ? neg_word(lo_q) : lo_q;
  assign rem_fix_s  = dvd_neg_q ? neg_word(hi_q) : hi_q;

  // Next-state of operand and accumulator registers
  always_comb begin
    op_d      = op_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    dvd_neg_d = dvd_neg_q;
    if (load) begin
      op_d      = funct3;
      hi_d      = 32'h0000_0000;
      neg_d     = sgn1_s ^ sgn2_s;
      dvd_neg_d = sgn1_s;
      if (funct3[2]) begin
        lo_d = mag1_s;
        b_d  = mag2_s;
      end else begin
        lo_d = mag2_s;
        b_d  = mag1_s;
      end
    end else if (step) begin
      if (op_q[2]) begin
        if (!div_diff_s[MD_XLEN]) begin
          hi_d = div_diff_s[MD_XLEN-1:0];
          lo_d = {lo_q[MD_XLEN-2:0], 1'b1};
        end else begin
          hi_d = div_shift_s[MD_XLEN-1:0];
          lo_d = {lo_q[MD_XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum_s[MD_XLEN:1];
        lo_d = {mul_sum_s[0], lo_q[MD_XLEN-1:1]};
      end
    end else begin
      op_d = op_q;
    end
  end

  // Word selection after sign correction
  always_comb begin
    case (op_q)
      F3_MUL:                       sel_s = prod_fix_s[MD_XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: sel_s = prod_fix_s[2*MD_XLEN-1:MD_XLEN];
      F3_DIV, F3_DIVU:              sel_s = quo_fix_s;
      F3_REM, F3_REMU:              sel_s = rem_fix_s;
      default:                      sel_s = prod_fix_s[MD_XLEN-1:0];
    endcase
  end

  // RESULT only changes when an operation completes
  always_comb begin
    result_d = result_q;
    if (fast) begin
      result_d = fast_result;
    end else if (fix) begin
      result_d = sel_s;
    end else begin
      result_d = result_q;
    end
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= 3'b000;
      b_q       <= 32'h0000_0000;
      hi_q      <= 32'h0000_0000;
      lo_q      <= 32'h0000_0000;
      neg_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      result_q  <= 32'h0000_0000;
    end else begin
      op_q      <= op_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      dvd_neg_q <= dvd_neg_d;
      result_q  <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/mul_div_controller.sv
// RV32M multiply/divide sequencer for the EX stage.
// Runs 32 shift-add or restoring-divide iterations, then a sign-fix cycle,
// then pulses DONE. Divide-by-zero and signed overflow finish in one cycle.
// Ports:
//   CLK     clock, all state changes on the rising edge
//   RESET   synchronous active-low reset
//   START   valid M-op in EX this cycle
//   FUNCT3  M-op select (MUL..REMU)
//   DATA1   rs1 operand, DATA2 rs2 operand
//   FLUSH   abort current operation (priority over START)
//   BUSY    combinational stall request
//   DONE    one-cycle pulse, RESULT valid
//   RESULT  registered result, held until the next DONE
module mul_div_controller
  import mul_div_controller_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  state_e                state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  done_q, done_d;

  logic                  div_zero_s, div_ovf_s, fast_hit_s;
  logic                  accept_s, load_s, step_s, fix_s, fast_s;
  logic [XLEN-1:0]       fast_result_s;

  assign div_zero_s = FUNCT3[2] & (DATA2 == 32'h0000_0000);
  assign div_ovf_s  = FUNCT3[2] & ~FUNCT3[0] &
                      (DATA1 == 32'h8000_0000) & (DATA2 == 32'hFFFF_FFFF);
  assign fast_hit_s = div_zero_s | div_ovf_s;

  // Fast-path answers; FUNCT3[1] distinguishes remainder from quotient
  always_comb begin
    fast_result_s = 32'h0000_0000;
    if (div_zero_s) begin
      fast_result_s = FUNCT3[1] ? DATA1 : 32'hFFFF_FFFF;
    end else if (div_ovf_s) begin
      fast_result_s = FUNCT3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end else begin
      fast_result_s = 32'h0000_0000;
    end
  end

  assign accept_s = (state_q == S_IDLE) & START & ~FLUSH;
  assign load_s   = accept_s & ~fast_hit_s;
  assign fast_s   = accept_s & fast_hit_s;
  // Gating with FLUSH keeps a flushed op from touching RESULT
  assign step_s   = (state_q == S_CALC) & ~FLUSH;
  assign fix_s    = (state_q == S_SIGN) & ~FLUSH;

  // FSM next state, iteration counter and DONE pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (FLUSH) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            cnt_d   = 5'd0;
            state_d = fast_hit_s ? S_DONE : S_CALC;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_SIGN;
          end else begin
            state_d = S_CALC;
          end
        end
        S_SIGN:  state_d = S_DONE;
        // START is ignored here: the op in EX is the one completing
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    done_d = (state_d == S_DONE);
  end

  // FSM registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  mul_div_datapath u_datapath (
    .clk         (CLK),
    .rst_n       (RESET),
    .load        (load_s),
    .step        (step_s),
    .fix         (fix_s),
    .fast        (fast_s),
    .funct3      (FUNCT3),
    .data1       (DATA1),
    .data2       (DATA2),
    .fast_result (fast_result_s),
    .result      (RESULT)
  );

  // Stall is raised in the same cycle the op is presented
  assign BUSY = RESET & (accept_s | (state_q == S_CALC) | (state_q == S_SIGN));
  assign DONE = done_q;

endmodule

// File: tb/tb_mul_div_controller.sv
// Self-checking bench for mul_div_controller: a scoreboard queue of
// expected results/completion cycles filled by the stimulus and drained by
// a monitor on every DONE; expected values come from plain integer maths.
module tb_mul_div_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] data1, data2;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          iss;
    int          done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ndone  = 0;
  int          cyc    = 0;
  bit          chk_busy = 1'b0;
  logic [31:0] last_res = 32'h0;

  mul_div_controller dut (
    .CLK(clk), .RESET(rst_n), .START(start), .FUNCT3(funct3),
    .DATA1(data1), .DATA2(data2), .FLUSH(flush),
    .BUSY(busy), .DONE(done), .RESULT(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model straight from the RV32M definitions
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb;
    logic [63:0] p;
    ia = a; ib = b; sa = ia; sb = ib;
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      default: begin
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : a;
          return f[1] ? (ia % ib) : (ia / ib);
        end
        return f[1] ? (a % b) : (a / b);
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: BUSY window and every DONE checked against the scoreboard
  always @(negedge clk) begin
    logic exp_b;
    exp_t e;
    if (rst_n === 1'b1) begin
      if (chk_busy) begin
        exp_b = (sb_q.size() > 0) && (cyc >= sb_q[0].iss) && (cyc < sb_q[0].done_cyc);
        checks++;
        if (busy !== exp_b) begin
          errors++;
          $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, exp_b);
        end
      end
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done cyc=%0d result=%h", cyc, result);
        end else begin
          e = sb_q.pop_front();
          checks += 2;
          if (result !== e.res) begin
            errors++;
            $display("FAIL result cyc=%0d got %h expected %h", cyc, result, e.res);
          end
          if (cyc != e.done_cyc) begin
            errors++;
            $display("FAIL latency got done at %0d expected %0d", cyc, e.done_cyc);
          end
          ndone++;
        end
      end
    end
  end

  // Issue one op (called at posedge+1 with the DUT idle) and wait for it
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n0, t;
    e.res = ref_result(f, a, b);
    e.iss = cyc;
    e.done_cyc = cyc + ref_latency(f, a, b);
    last_res = e.res;
    n0 = ndone;
    sb_q.push_back(e);
    funct3 = f; data1 = a; data2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); data1 = $urandom; data2 = $urandom;
    t = 0;
    while (ndone == n0 && t < 40) begin
      @(posedge clk); #1; t++;
    end
    if (ndone == n0) begin
      checks++; errors++;
      $display("FAIL timeout op=%b a=%h b=%h got no DONE expected one", f, a, b);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, expv);
    end
  endtask

  initial begin
    int n, n0;
    exp_t e;
    rst_n = 1'b0; start = 1'b1; flush = 1'b0; funct3 = 3'b000;
    data1 = 32'd3; data2 = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk_busy = 1'b1;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2);
    run_op(3'b101, 32'd100, 32'd7);
    run_op(3'b111, 32'd100, 32'd7);
    run_op(3'b101, 32'd5, 32'd0);
    run_op(3'b111, 32'd5, 32'd0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

    // FLUSH ten cycles into a DIV
    chk_busy = 1'b0;
    funct3 = 3'b100; data1 = 32'd1000; data2 = 32'd7; start = 1'b1; n = cyc;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; #1;
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy_after", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result_held", result, last_res);
    check("flush_cycle", cyc, n + 11);
    chk_busy = 1'b1;
    run_op(3'b100, 32'd1000, 32'hFFFF_FFF9);

    // Reset in the middle of a MUL
    chk_busy = 1'b0;
    funct3 = 3'b000; data1 = 32'd12345; data2 = 32'd678; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("midreset_result", result, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1; last_res = 32'd0;
    @(posedge clk); #1;
    chk_busy = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // START held high through the DONE cycle must not re-issue
    e.res = ref_result(3'b001, 32'h1234_5678, 32'h8765_4321);
    e.iss = cyc; e.done_cyc = cyc + 34;
    sb_q.push_back(e);
    n0 = ndone;
    funct3 = 3'b001; data1 = 32'h1234_5678; data2 = 32'h8765_4321; start = 1'b1;
    n = 0;
    while (ndone == n0 && n < 40) begin @(posedge clk); #1; n++; end
    start = 1'b0;
    check("held_start_completed", ndone, n0 + 1);
    repeat (40) begin @(posedge clk); #1; end
    check("held_start_no_reissue", ndone, n0 + 1);

    // Randomized operations with corner-biased operands
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick());
    end

    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
